// File: rtl/key_pkg.sv
// Shared types and constants for the key bounce generator.
// State encoding, LFSR geometry/seed and key polarity levels.
package key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE           = 2'd0,
    ST_BOUNCE_PRESS   = 2'd1,
    ST_HOLD           = 2'd2,
    ST_BOUNCE_RELEASE = 2'd3
  } state_t;

  localparam int          LFSR_W        = 16;
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_DEF_SEED = 16'hACE1;

  localparam logic KEY_RELEASED = 1'b1;
  localparam logic KEY_PRESSED  = 1'b0;

  // x^16+x^14+x^13+x^11+1, shifting left with the
  // parity of the tapped bits fed into bit 0.
  function automatic logic [15:0] lfsr_next(
    input logic [15:0] q
  );
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

  // An all-zero seed would lock the register.
  function automatic logic [15:0] seed_fix(
    input logic [15:0] s
  );
    return (s == 16'h0000) ? LFSR_DEF_SEED : s;
  endfunction

endpackage

// File: rtl/key_bounce_gen_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, reloads seed on reset.
// Ports: clk, rst_n (async, active-low), q[15:0] current state.
module lfsr16
  import key_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_DEF_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  localparam logic [15:0] INIT = seed_fix(SEED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= INIT;
    else        q <= lfsr_next(q);
  end

endmodule

// File: rtl/key_bounce_gen.sv
// Emulated mechanical key: bounce, steady low hold, bounce.
// Ports: sys_clk, sys_rst_n, press_req in; busy, key_out, press_done out.
module key_bounce_gen
  import key_pkg::*;
#(
  parameter int unsigned BOUNCE_CYCLES = 30,
  parameter int unsigned HOLD_CYCLES   = 100,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic press_req,
  output logic busy,
  output logic key_out,
  output logic press_done
);

  localparam logic [15:0] B_LAST = 16'(BOUNCE_CYCLES - 1);
  localparam logic [15:0] H_LAST = 16'(HOLD_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        key_nxt;
  logic        busy_nxt;
  logic        done_nxt;
  logic [15:0] lfsr_q;
  logic        rnd;
  logic        lfsr_unused;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .q     (lfsr_q)
  );

  assign rnd         = lfsr_q[0];
  assign lfsr_unused = ^lfsr_q[15:1];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      key_out    <= KEY_RELEASED;
      busy       <= 1'b0;
      press_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      key_out    <= key_nxt;
      busy       <= busy_nxt;
      press_done <= done_nxt;
    end
  end

  // cnt counts edges already spent in the state, so
  // the exit edge is the one that sees cnt == LAST.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 16'd1;
    key_nxt   = key_out;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        key_nxt = KEY_RELEASED;
        if (press_req) begin
          state_nxt = ST_BOUNCE_PRESS;
          busy_nxt  = 1'b1;
          key_nxt   = rnd;
        end
      end
      ST_BOUNCE_PRESS: begin
        if (cnt == B_LAST) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
          key_nxt   = KEY_PRESSED;
        end else begin
          key_nxt = rnd;
        end
      end
      ST_HOLD: begin
        if (cnt == H_LAST) begin
          state_nxt = ST_BOUNCE_RELEASE;
          cnt_nxt   = '0;
          key_nxt   = rnd;
        end else begin
          key_nxt = KEY_PRESSED;
        end
      end
      ST_BOUNCE_RELEASE: begin
        if (cnt == B_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          key_nxt   = KEY_RELEASED;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          key_nxt = rnd;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_key_bounce_gen.sv
// Directed bench for key_bounce_gen (B=30/H=100 and B=1/H=1 seed 0).
// Expected key levels come from an independent LFSR model.
module tb_key_bounce_gen;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic req0 = 1'b0;
  logic req1 = 1'b0;
  logic busy0, key0, done0;
  logic busy1, key1, done1;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_lfsr;

  always #5 sys_clk = ~sys_clk;

  key_bounce_gen #(
    .BOUNCE_CYCLES (30),
    .HOLD_CYCLES   (100),
    .LFSR_SEED     (16'hACE1)
  ) dut0 (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .press_req  (req0),
    .busy       (busy0),
    .key_out    (key0),
    .press_done (done0)
  );

  key_bounce_gen #(
    .BOUNCE_CYCLES (1),
    .HOLD_CYCLES   (1),
    .LFSR_SEED     (16'h0000)
  ) dut1 (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .press_req  (req1),
    .busy       (busy1),
    .key_out    (key1),
    .press_done (done1)
  );

  // Reference LFSR: taps 16,14,13,11 -> bits 15,13,12,10.
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      m_lfsr <= 16'hACE1;
    else
      m_lfsr <= {m_lfsr[14:0],
                 m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input bit sel, input logic v);
    if (sel) req1 = v;
    else     req0 = v;
  endtask

  // Drives one sequence from E0 and checks every edge up to
  // E(2B+H). abort_k >= 0 asserts reset mid-cycle after Ek.
  task automatic run_seq(input bit sel, input int b, input int h,
                         input bit hold, input bit extra,
                         input int abort_k);
    int n;
    logic bit_e;
    logic ek;
    n = 2*b + h;
    set_req(sel, 1'b1);
    for (int k = 0; k <= n; k++) begin
      bit_e = m_lfsr[0];
      @(posedge sys_clk);
      #1;
      if (!hold) set_req(sel, 1'b0);
      if (k < b)          ek = bit_e;
      else if (k < b + h) ek = 1'b0;
      else if (k < n)     ek = bit_e;
      else                ek = 1'b1;
      chk($sformatf("key%0d E%0d", sel, k),
          32'(sel ? key1 : key0), 32'(ek));
      chk($sformatf("busy%0d E%0d", sel, k),
          32'(sel ? busy1 : busy0), 32'(k < n));
      chk($sformatf("done%0d E%0d", sel, k),
          32'(sel ? done1 : done0), 32'(k == n));
      if (k == abort_k) begin
        #2 sys_rst_n = 1'b0;
        #1;
        chk("abort key", 32'(key0), 32'd1);
        chk("abort busy", 32'(busy0), 32'd0);
        chk("abort done", 32'(done0), 32'd0);
        return;
      end
      if (extra && (k == 9 || k == 49 || k == 139))
        set_req(sel, 1'b1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
      chk("idle key0", 32'(key0), 32'd1);
      chk("idle done0", 32'(done0), 32'd0);
    end
  endtask

  initial begin
    req0 = 1'b1;
    req1 = 1'b1;
    repeat (3) begin
      @(posedge sys_clk);
      #1;
      chk("rst key0", 32'(key0), 32'd1);
      chk("rst busy0", 32'(busy0), 32'd0);
      chk("rst done0", 32'(done0), 32'd0);
      chk("rst key1", 32'(key1), 32'd1);
      chk("rst busy1", 32'(busy1), 32'd0);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    run_seq(1'b0, 30, 100, 1'b0, 1'b0, -1);
    idle(4);
    run_seq(1'b0, 30, 100, 1'b0, 1'b1, -1);
    idle(4);
    run_seq(1'b0, 30, 100, 1'b1, 1'b0, -1);
    run_seq(1'b0, 30, 100, 1'b0, 1'b0, -1);
    idle(3);
    run_seq(1'b1, 1, 1, 1'b0, 1'b0, -1);
    run_seq(1'b1, 1, 1, 1'b0, 1'b0, -1);
    idle(2);

    run_seq(1'b0, 30, 100, 1'b0, 1'b0, 70);
    repeat (3) begin
      @(posedge sys_clk);
      #1;
      chk("in rst key0", 32'(key0), 32'd1);
      chk("in rst done0", 32'(done0), 32'd0);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    run_seq(1'b0, 30, 100, 1'b0, 1'b0, -1);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_bounce_gen.md
Name: key_bounce_gen

Overview:
Synthesizable generator of a mechanical-key waveform: a press request produces an active-low key signal with pseudo-random contact bounce on press and on release, and a clean low hold between them. It is the transmit end of the key_filter path. It drives key_filter (or a board pin) in hardware-in-loop and self-checking benches, replacing ad-hoc $random stimulus.
Output is deterministic for a given seed, so filter results are reproducible.

Parameters:
BOUNCE_CYCLES, 30, clock cycles of random bounce on each edge (press and release); legal 1..65535
HOLD_CYCLES, 100, clock cycles key_out is held steady low between bounces; legal 1..65535
LFSR_SEED, 16'hACE1, reset value of the bounce LFSR; 16'h0000 is replaced internally by 16'hACE1

Ports:
sys_clk  in  1  system clock, rising edge
sys_rst_n  in  1  reset; asynchronous assert, active-low
press_req  in  1  request one press/release sequence; sampled every rising edge
busy  out  1  high while a sequence is in progress
key_out  out  1  emulated key; 1 = released (idle), 0 = pressed; registered
press_done  out  1  one-cycle pulse when the sequence completes and key_out returns to 1

Behaviour:
- Reset (sys_rst_n=0, asynchronous): state IDLE, key_out=1, busy=0, press_done=0, counter=0, LFSR=LFSR_SEED.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. Free-running: advances every clock after reset, in every state. The bounce bit is lfsr[0].
- States: IDLE -> BOUNCE_PRESS -> HOLD -> BOUNCE_RELEASE -> IDLE. The 16-bit counter cnt is cleared on every state entry.
- Edge numbering: E0 is the rising edge that samples press_req=1 in IDLE.
- IDLE: key_out=1, busy=0. At E0, the block enters BOUNCE_PRESS, busy<=1 and key_out<=lfsr[0].
- BOUNCE_PRESS: key_out<=lfsr[0] on each edge E0..E(B-1), where B=BOUNCE_CYCLES. At E(B) the block enters HOLD and key_out<=0.
- HOLD: key_out=0 for edges E(B)..E(B+H-1), where H=HOLD_CYCLES. At E(B+H) the block enters BOUNCE_RELEASE and key_out<=lfsr[0].
- BOUNCE_RELEASE: key_out random for edges E(B+H)..E(2B+H-1). At E(2B+H) the block enters IDLE with key_out<=1, busy<=0 and press_done<=1.
- press_done: high for exactly one cycle, cleared at the next edge.
- Total sequence length: 2B+H cycles.
- press_req while busy=1: ignored, no queuing.
- press_req held high continuously: a new sequence starts at E(2B+H+1). The IDLE gap is exactly one cycle, during which press_done=1 and key_out=1.
- press_req is level-sampled, and only in IDLE. A single-cycle pulse is sufficient.
- Reset mid-sequence: immediate return to the reset values; no press_done is issued.
- Boundary B=1 or H=1: the state lasts exactly one cycle; no zero-length states.
- Seed 0 guard: the LFSR loads 16'hACE1 and never reaches the all-zero lock state.

Decomposition:
- Shared package key_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_BOUNCE_PRESS=2'd1, ST_HOLD=2'd2, ST_BOUNCE_RELEASE=2'd3
  - LFSR width 16, tap mask 16'hB400, default seed 16'hACE1
  - KEY_RELEASED=1'b1 and KEY_PRESSED=1'b0
- One sub-module lfsr16 (clk, rst_n, seed parameter, q[15:0]), reusable by other stimulus generators.
- FSM and counter stay in key_bounce_gen.

Test Plan:
- Reset: hold sys_rst_n=0 for 3 cycles -> key_out=1, busy=0, press_done=0 throughout; press_req=1 during reset is ignored.
- Single press (B=30, H=100), press_req pulse at E0:
  - busy=1 from E0 to E159
  - key_out=0 at every edge E30..E129
  - key_out random at E0..E29 and E130..E159
  - key_out=1 and press_done=1 at E160 only; busy=0 at E160
- Ignored request: extra press_req pulses at E10, E50 and E140 -> same waveform and timing as the single-press case; exactly one press_done.
- Back-to-back: press_req held high -> second busy rise at E161; press_done pulses at E160 and E321; key_out=1 at E160.
- Reset mid-HOLD (at E70) -> key_out=1 and busy=0 asynchronously, no press_done. A new press after release repeats the exact key_out sequence of the first run, because the LFSR is reseeded.
- Connected to key_filter (CNT_MAX=24), B=30, H=100 -> exactly one key_flag per sequence, asserted within HOLD, none during either bounce window.
